// File: rtl/ahb_arb_pkg.sv
// Shared constants and helpers for the AHB QoS arbiter.
package ahb_arb_pkg;

    // Static priority encoding of the fabric masters; higher value wins.
    localparam int unsigned PRIO_DMA = 0;
    localparam int unsigned PRIO_NET = 1;
    localparam int unsigned PRIO_CIM = 2;
    localparam int unsigned PRIO_CPU = 3;

    localparam int unsigned DEFAULT_AGE_W = 8;
    localparam int unsigned MAX_MASTERS   = 16;

    // Index of the set bit of a one-hot vector (0 when the vector is zero).
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_MASTERS); i++) begin
            if (oh[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating first-one selector: first set bit of cand scanning from ptr+1 upward, wrapping.
module ahb_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    logic [IDX_W-1:0] sel;

    // Scan N positions starting just after the pointer; the pointer itself is checked last.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        any         = 1'b0;
        sel         = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            sel = IDX_W'((32'(ptr) + k) % N);
            if (!any && cand[sel]) begin
                any              = 1'b1;
                pick_idx         = sel;
                pick_onehot[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_qos_arbiter.sv
// AHB master arbiter: registered grants on HREADY, static priority with round-robin tie-break,
// locked-burst ownership and starvation aging.
module ahb_qos_arbiter import ahb_arb_pkg::*; #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned PRIO_W      = 2,
    parameter int unsigned AGE_W       = DEFAULT_AGE_W,
    parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS*PRIO_W-1:0] prio,
    input  logic [NUM_MASTERS-1:0]        lock,
    input  logic                          hready,
    input  logic [AGE_W-1:0]              age_thresh,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic [IDX_W-1:0]              winner,
    output logic                          grant_valid,
    output logic                          boosted
);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   grant_valid_q, grant_valid_d;
    logic                   boosted_q, boosted_d;
    logic [AGE_W-1:0]       age_q [NUM_MASTERS];
    logic [AGE_W-1:0]       age_d [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] starved;
    logic [NUM_MASTERS-1:0] top_prio;
    logic [NUM_MASTERS-1:0] cand;
    logic [PRIO_W-1:0]      max_prio;
    logic                   any_starved;
    logic                   hold_lock;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    // Candidate filter: starved requesters outrank everyone, else the highest static priority.
    always_comb begin
        starved  = '0;
        top_prio = '0;
        max_prio = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            starved[i] = req[i] && (age_thresh != '0) && (age_q[i] >= age_thresh);
            if (req[i] && (prio[i*PRIO_W +: PRIO_W] > max_prio)) begin
                max_prio = prio[i*PRIO_W +: PRIO_W];
            end
        end
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            top_prio[i] = req[i] && (prio[i*PRIO_W +: PRIO_W] == max_prio);
        end
        any_starved = |starved;
        cand        = any_starved ? starved : top_prio;
    end

    ahb_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .cand        (cand),
        .ptr         (rr_ptr_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .any         (pick_any)
    );

    // The current owner keeps the bus while it still requests with lock asserted.
    assign hold_lock = grant_valid_q && lock[winner_q] && req[winner_q];

    // Next grant state; only an HREADY edge without a held lock takes a new arbitration result.
    always_comb begin
        grant_d       = grant_q;
        winner_d      = winner_q;
        rr_ptr_d      = rr_ptr_q;
        grant_valid_d = grant_valid_q;
        boosted_d     = boosted_q;
        if (hready && !hold_lock) begin
            grant_d       = pick_onehot;
            grant_valid_d = pick_any;
            boosted_d     = pick_any && any_starved;
            // Winner holds its last value when nobody requests so the mux select stays quiet.
            if (pick_any) begin
                winner_d = pick_idx;
                rr_ptr_d = pick_idx;
            end
        end
    end

    // Per-master wait counters: clear when idle or granted, otherwise saturating increment.
    always_comb begin
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            age_d[i] = age_q[i];
            if (!req[i] || grant_q[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != '1) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    // State registers; reset forgets any lock and hands master 0 the first tie-break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q       <= '0;
            winner_q      <= '0;
            rr_ptr_q      <= IDX_W'(NUM_MASTERS - 1);
            grant_valid_q <= 1'b0;
            boosted_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                age_q[i] <= '0;
            end
        end else begin
            grant_q       <= grant_d;
            winner_q      <= winner_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_valid_q <= grant_valid_d;
            boosted_q     <= boosted_d;
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign grant       = grant_q;
    assign winner      = winner_q;
    assign grant_valid = grant_valid_q;
    assign boosted     = boosted_q;

    // Grant is one-hot or zero, and the winner index agrees with a live grant.
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_winner_match : assert property (@(posedge clk) disable iff (!rst_n)
        grant_valid_q |-> (winner_q == IDX_W'(onehot_to_idx(MAX_MASTERS'(grant_q)))));

endmodule

// File: tb/tb_ahb_qos_arbiter.sv
// Directed self-checking bench for ahb_qos_arbiter.
module tb_ahb_qos_arbiter;
    import ahb_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] req, lock;
    logic [7:0] prio;
    logic       hready;
    logic [7:0] age_thresh;
    logic [3:0] grant;
    logic [1:0] winner;
    logic       grant_valid, boosted;

    // Second instance with narrow age counters for the saturation check.
    logic [3:0] req_s, lock_s;
    logic [7:0] prio_s;
    logic [2:0] age_thresh_s;
    logic [3:0] grant_s;
    logic [1:0] winner_s;
    logic       grant_valid_s, boosted_s;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    ahb_qos_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .prio        (prio),
        .lock        (lock),
        .hready      (hready),
        .age_thresh  (age_thresh),
        .grant       (grant),
        .winner      (winner),
        .grant_valid (grant_valid),
        .boosted     (boosted)
    );

    ahb_qos_arbiter #(.AGE_W(3)) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_s),
        .prio        (prio_s),
        .lock        (lock_s),
        .hready      (1'b1),
        .age_thresh  (age_thresh_s),
        .grant       (grant_s),
        .winner      (winner_s),
        .grant_valid (grant_valid_s),
        .boosted     (boosted_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req          = '0;
        lock         = '0;
        prio         = '0;
        hready       = 1'b1;
        age_thresh   = '0;
        req_s        = '0;
        lock_s       = '0;
        prio_s       = '0;
        age_thresh_s = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_winner", 32'(winner), 0);
        check_eq("rst_valid", 32'(grant_valid), 0);
        check_eq("rst_boosted", 32'(boosted), 0);

        // Static priority: m0=CPU, m1=CIM, m2=NET, m3=DMA
        do_reset();
        prio = {2'(PRIO_DMA), 2'(PRIO_NET), 2'(PRIO_CIM), 2'(PRIO_CPU)};
        req  = 4'b1111;
        tick();
        check_eq("prio_first", 32'(grant), 1);
        check_eq("prio_valid", 32'(grant_valid), 1);
        tick();
        tick();
        check_eq("prio_stay", 32'(grant), 1);
        req = 4'b1110;
        tick();
        check_eq("prio_next", 32'(grant), 2);
        check_eq("prio_next_winner", 32'(winner), 1);

        // Round-robin among equal priorities
        do_reset();
        prio = 8'b01_01_01_01;
        req  = 4'b1111;
        begin
            logic [3:0] seq [5];
            seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            for (int i = 0; i < 5; i++) begin
                tick();
                check_eq($sformatf("rr_%0d", i), 32'(grant), 32'(seq[i]));
            end
        end

        // Locked burst held against a higher-priority request
        do_reset();
        prio = {2'(PRIO_DMA), 2'(PRIO_NET), 2'(PRIO_CIM), 2'(PRIO_CPU)};
        req  = 4'b1000;
        lock = 4'b1000;
        tick();
        check_eq("lock_own", 32'(grant), 8);
        req = 4'b1001;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (grant != 4'b1000) cnt++;
        end
        check_eq("lock_hold", 32'(cnt), 0);
        lock = 4'b0000;
        tick();
        check_eq("lock_release", 32'(grant), 1);

        // HREADY low freezes the grant even after the owner drops req
        do_reset();
        prio = {2'(PRIO_DMA), 2'(PRIO_NET), 2'(PRIO_CIM), 2'(PRIO_CPU)};
        req  = 4'b1000;
        lock = 4'b1000;
        tick();
        hready = 1'b0;
        req    = 4'b0001;
        lock   = 4'b0000;
        cnt    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant != 4'b1000 || !grant_valid) cnt++;
        end
        check_eq("hready_freeze", 32'(cnt), 0);
        hready = 1'b1;
        tick();
        check_eq("hready_resume", 32'(grant), 1);

        // Aging: m3 waits 8 cycles behind m0, then wins boosted
        do_reset();
        prio       = {2'(PRIO_DMA), 2'(PRIO_NET), 2'(PRIO_CIM), 2'(PRIO_CPU)};
        req        = 4'b1001;
        age_thresh = 8'd8;
        cnt        = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (grant != 4'b0001 || boosted) cnt++;
        end
        check_eq("age_m0_wins", 32'(cnt), 0);
        tick();
        check_eq("age_boost_grant", 32'(grant), 8);
        check_eq("age_boost_flag", 32'(boosted), 1);
        tick();
        check_eq("age_m3_cleared", 32'(dut.age_q[3]), 0);
        tick();
        check_eq("age_back_m0", 32'(grant), 1);
        check_eq("age_back_flag", 32'(boosted), 0);

        // Aging disabled: m3 never granted
        do_reset();
        prio = {2'(PRIO_DMA), 2'(PRIO_NET), 2'(PRIO_CIM), 2'(PRIO_CPU)};
        req  = 4'b1001;
        cnt  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (grant[3]) cnt++;
        end
        check_eq("noage_m3_never", 32'(cnt), 0);

        // Saturation with 3-bit counters: m1 waits 20 cycles behind locked m0
        do_reset();
        prio_s = 8'b00_00_00_11;
        req_s  = 4'b0011;
        lock_s = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_owner", 32'(grant_s), 1);
        check_eq("sat_age", 32'(dut_s.age_q[1]), 7);
        req_s  = 4'b0000;
        lock_s = 4'b0000;
        tick();
        check_eq("idle_grant", 32'(grant_s), 0);
        check_eq("idle_valid", 32'(grant_valid_s), 0);

        // Asynchronous reset during a locked m2 burst
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        tick();
        check_eq("mid_locked", 32'(grant), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_grant", 32'(grant), 0);
        check_eq("mid_rst_valid", 32'(grant_valid), 0);
        prio = 8'b01_01_01_01;
        req  = 4'b1111;
        lock = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_grant", 32'(grant), 1);
        check_eq("post_rst_winner", 32'(winner), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
